// File: rtl/cond_pkg.sv
// Shared condition-code definitions: ARM condition encodings, flag bit
// positions and default widths used by the issue queue and later stages.
package cond_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 4;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    // Positions inside the 4-bit flags nibble {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Positions inside the 32-bit status register
    localparam int CPSR_N = 31;
    localparam int CPSR_V = 28;

    function automatic logic [3:0] cpsr_flags(input logic [31:0] cpsr);
        return cpsr[CPSR_N:CPSR_V];
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition check: pass=1 when the condition holds for
// the given {N,Z,C,V} flags. NV never passes.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_issue_queue.sv
// Circular issue queue whose head instruction is checked against the live
// status flags at dequeue time; failed heads are dropped or forwarded killed.
module cond_issue_queue
    import cond_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int KILL_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [DATA_W-1:0]       dataIn,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [DATA_W-1:0]       dataOut,
    output logic                    killOut,
    input  logic [31:0]             cpsr,
    input  logic                    flagsValid,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output logic [15:0]             issueCount,
    output logic [15:0]             squashCount
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [15:0]       issue_cnt_reg, squash_cnt_reg;

    logic              empty, full, enq, deq;
    logic              head_live, head_pass;
    logic [DATA_W-1:0] head;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]) &&
                   (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]);
    assign head  = mem_reg[rd_ptr_reg[IDX_W-1:0]];

    cond_eval u_cond_eval (
        .cond  (head[DATA_W-1 -: 4]),
        .flags (cpsr_flags(cpsr)),
        .pass  (head_pass)
    );

    // A head is only acted on while the flags are trustworthy
    assign head_live = !empty && flagsValid;
    assign outValid  = head_live && (head_pass || KILL_MODE != 0);
    assign killOut   = outValid && !head_pass;
    assign dataOut   = outValid ? head : '0;
    assign inReady   = !full;
    assign count     = wr_ptr_reg - rd_ptr_reg;

    assign enq = inValid && !full && !flush;
    // Failing heads in drop mode leave without a downstream handshake
    assign deq = head_live && (outValid ? outReady : 1'b1);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    mem_reg[gi] <= '0;
                end else if (enq && wr_ptr_reg[IDX_W-1:0] == IDX_W'(gi)) begin
                    mem_reg[gi] <= dataIn;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            issue_cnt_reg  <= '0;
            squash_cnt_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                if (head_pass) issue_cnt_reg  <= issue_cnt_reg + 1'b1;
                else           squash_cnt_reg <= squash_cnt_reg + 1'b1;
            end
        end
    end

    assign issueCount  = issue_cnt_reg;
    assign squashCount = squash_cnt_reg;

endmodule

// File: tb/tb_cond_issue_queue.sv
// Bench for cond_issue_queue: drop-mode and kill-mode instances share one
// stimulus stream; a negedge monitor checks both against per-instance models.
module tb_cond_issue_queue;

    localparam int DW = 32;
    localparam int DP = 4;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic        out_ready = 1'b0;
    logic [31:0] cpsr = '0;
    logic        flags_valid = 1'b0;
    logic        flush = 1'b0;

    logic        in_ready  [2];
    logic        out_valid [2];
    logic [31:0] data_out  [2];
    logic        kill_out  [2];
    logic [2:0]  count_o   [2];
    logic [15:0] issue_o   [2];
    logic [15:0] squash_o  [2];

    always #5 clk = ~clk;

    cond_issue_queue #(.DATA_W(DW), .DEPTH(DP), .KILL_MODE(0)) dut0 (
        .clk(clk), .rstN(rstN), .inValid(in_valid), .inReady(in_ready[0]),
        .dataIn(data_in), .outValid(out_valid[0]), .outReady(out_ready),
        .dataOut(data_out[0]), .killOut(kill_out[0]), .cpsr(cpsr),
        .flagsValid(flags_valid), .flush(flush), .count(count_o[0]),
        .issueCount(issue_o[0]), .squashCount(squash_o[0])
    );

    cond_issue_queue #(.DATA_W(DW), .DEPTH(DP), .KILL_MODE(1)) dut1 (
        .clk(clk), .rstN(rstN), .inValid(in_valid), .inReady(in_ready[1]),
        .dataIn(data_in), .outValid(out_valid[1]), .outReady(out_ready),
        .dataOut(data_out[1]), .killOut(kill_out[1]), .cpsr(cpsr),
        .flagsValid(flags_valid), .flush(flush), .count(count_o[1]),
        .issueCount(issue_o[1]), .squashCount(squash_o[1])
    );

    // Reference state: accepted instructions in order, tagged with the
    // cycle they were accepted in (not visible until the following cycle).
    logic [31:0] m_d [2][8];
    int          m_c [2][8];
    int          m_n [2];
    logic [15:0] m_iss [2];
    logic [15:0] m_sq  [2];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit run = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Condition rules: even codes are base predicates, odd codes their negation
    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0; m_iss[k] = '0; m_sq[k] = '0;
        end
    endtask

    int          vis;
    logic [31:0] hd;
    bit          hok, pss, ev;

    always @(negedge clk) begin
        if (rstN && run) begin
            for (int k = 0; k < 2; k++) begin
                vis = m_n[k];
                if (vis > 0 && m_c[k][vis-1] == cyc) vis = vis - 1;
                hd  = m_d[k][0];
                hok = (vis > 0) && flags_valid;
                pss = ref_pass(hd[31:28], cpsr[31:28]);
                ev  = hok && (pss || k == 1);
                chk("outValid", k, {31'b0, out_valid[k]}, {31'b0, ev});
                chk("dataOut",  k, data_out[k], ev ? hd : 32'h0);
                chk("killOut",  k, {31'b0, kill_out[k]}, {31'b0, ev && !pss});
                chk("count",    k, {29'b0, count_o[k]}, 32'(vis));
                chk("inReady",  k, {31'b0, in_ready[k]}, {31'b0, vis < DP});
                chk("issueCount",  k, {16'b0, issue_o[k]}, {16'b0, m_iss[k]});
                chk("squashCount", k, {16'b0, squash_o[k]}, {16'b0, m_sq[k]});
                if (flush) begin
                    m_n[k] = 0;
                end else if (hok && (ev ? out_ready : 1'b1)) begin
                    $display("cycle %0d dut%0d %s %h", cyc, k, pss ? "issue " : "squash", hd);
                    for (int i = 0; i < m_n[k] - 1; i++) begin
                        m_d[k][i] = m_d[k][i+1];
                        m_c[k][i] = m_c[k][i+1];
                    end
                    m_n[k] = m_n[k] - 1;
                    if (pss) m_iss[k] = m_iss[k] + 1'b1;
                    else     m_sq[k]  = m_sq[k] + 1'b1;
                end
            end
        end
    end

    // Drive one cycle of inputs; accepted instructions are pushed as expected
    task automatic step(input bit iv, input logic [31:0] d, input bit ordy,
                        input bit fv, input logic [31:0] cp, input bit fl);
        in_valid = iv; data_in = d; out_ready = ordy;
        flags_valid = fv; cpsr = cp; flush = fl;
        if (iv && !fl) begin
            for (int k = 0; k < 2; k++) begin
                if (m_n[k] < DP) begin
                    m_d[k][m_n[k]] = d;
                    m_c[k][m_n[k]] = cyc;
                    m_n[k] = m_n[k] + 1;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        rstN = 1'b0; in_valid = 1'b0; flush = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_inReady",  k, {31'b0, in_ready[k]}, 32'h1);
            chk("rst_outValid", k, {31'b0, out_valid[k]}, 32'h0);
            chk("rst_dataOut",  k, data_out[k], 32'h0);
            chk("rst_killOut",  k, {31'b0, kill_out[k]}, 32'h0);
            chk("rst_count",    k, {29'b0, count_o[k]}, 32'h0);
            chk("rst_issue",    k, {16'b0, issue_o[k]}, 32'h0);
            chk("rst_squash",   k, {16'b0, squash_o[k]}, 32'h0);
        end
        clear_model();
        @(posedge clk); #1;
        rstN = 1'b1;
    endtask

    logic [31:0] r, rc, d;

    initial begin
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        run = 1'b1;

        // AL instruction with cpsr=0 issues the cycle after enqueue
        step(1'b1, 32'hE1A00000, 1'b1, 1'b1, 32'h0, 1'b0);
        idle(2);

        // EQ with Z=0: dropped in drop mode, offered killed in kill mode
        step(1'b1, 32'h00001234, 1'b1, 1'b1, 32'h0, 1'b0);
        idle(2);

        // HI with C=1,Z=1 fails, then C=1,Z=0 passes while held
        step(1'b1, 32'h800000AB, 1'b0, 1'b1, 32'h60000000, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h60000000, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h60000000, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h20000000, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h20000000, 1'b0);
        idle(1);

        // Fill to full, fifth held; then dequeue alone and dequeue+enqueue
        for (int i = 0; i < 5; i++) step(1'b1, 32'hE0000000 + i, 1'b0, 1'b1, 32'h0, 1'b0);
        step(1'b1, 32'hE0000010, 1'b1, 1'b1, 32'h0, 1'b0);
        step(1'b1, 32'hE0000011, 1'b1, 1'b1, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        idle(5);

        // Flag hazard for three cycles holds a passing head
        step(1'b1, 32'hE0000020, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        idle(2);

        // Flush with three entries and a same-cycle enqueue
        for (int i = 0; i < 3; i++) step(1'b1, 32'hE0000030 + i, 1'b0, 1'b1, 32'h0, 1'b0);
        step(1'b1, 32'hE0000040, 1'b0, 1'b1, 32'h0, 1'b1);
        idle(2);

        // Reset mid-stream, then enqueue as from empty
        for (int i = 0; i < 2; i++) step(1'b1, 32'h10000050 + i, 1'b0, 1'b1, 32'h0, 1'b0);
        do_reset();
        step(1'b1, 32'hE0000060, 1'b1, 1'b1, 32'h0, 1'b0);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            r  = $urandom();
            rc = $urandom();
            d  = {rc[3:0], r[27:0]};
            step($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 8, {rc[7:4], 28'h0}, $urandom_range(0, 99) < 3);
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
